// File: rtl/dmem_pkg.sv
// Shared constants for the wait-state data memory: funct3 codes, FSM states, byte lanes.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Lane logic is built around a 32-bit word of four bytes.
  localparam int BE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane logic: store byte-enables and merge, load extract/extend, misalign flag.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       addr_lo,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] rword,
  output logic [BE_W-1:0]  be,
  output logic [WIDTH-1:0] wword,
  output logic [WIDTH-1:0] rdata,
  output logic             misalign
);

  logic [7:0]       b;
  logic [15:0]      h;
  logic [WIDTH-1:0] wrep;

  assign b = rword[{addr_lo, 3'b000} +: 8];
  assign h = rword[{addr_lo[1], 4'b0000} +: 16];

  // Unknown store widths fall through to a full-word write.
  always_comb begin
    be   = '1;
    wrep = wdata;
    case (funct3)
      F3_B: begin
        be   = BE_W'(1) << addr_lo;
        wrep = {BE_W{wdata[7:0]}};
      end
      F3_H: begin
        be   = BE_W'(3) << {addr_lo[1], 1'b0};
        wrep = {(BE_W/2){wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    rdata = rword;
    case (funct3)
      F3_B:  rdata = {{(WIDTH-8){b[7]}}, b};
      F3_BU: rdata = {{(WIDTH-8){1'b0}}, b};
      F3_H:  rdata = {{(WIDTH-16){h[15]}}, h};
      F3_HU: rdata = {{(WIDTH-16){1'b0}}, h};
      default: ;
    endcase
  end

  assign misalign = ((funct3 == F3_H || funct3 == F3_HU) && addr_lo[0]) ||
                    (funct3 == F3_W && addr_lo != 2'b00);

  for (genvar i = 0; i < BE_W; i++) begin : g_merge
    assign wword[8*i +: 8] = be[i] ? wrep[8*i +: 8] : rword[8*i +: 8];
  end

endmodule

// File: rtl/dmem_wait_responder.sv
// Word-organised data memory responder with WAIT_CYCLES wait states on a valid/ready channel.
// Define DMEM_ERR_EN to fault misaligned, illegal-funct3 and out-of-range accesses.
module dmem_wait_responder
  import dmem_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic [2:0]       req_funct3,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             a_write;
  logic [WIDTH-1:0] a_addr, a_wdata;
  logic [2:0]       a_f3;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             cur_write;
  logic [WIDTH-1:0] cur_addr, cur_wdata, rword, wword, rdata, ld_res;
  logic [2:0]       cur_f3;
  logic [AW-1:0]    idx;
  logic [BE_W-1:0]  be;
  logic             misalign, err, do_access;

  // With zero wait states the access happens on the accept edge, straight from the request pins.
  assign cur_write = (state == IDLE) ? req_write  : a_write;
  assign cur_addr  = (state == IDLE) ? req_addr   : a_addr;
  assign cur_wdata = (state == IDLE) ? req_wdata  : a_wdata;
  assign cur_f3    = (state == IDLE) ? req_funct3 : a_f3;
  assign idx       = cur_addr[AW+1:2];
  assign rword     = mem[idx];

  dmem_lane_align #(.WIDTH(WIDTH)) u_align (
    .addr_lo  (cur_addr[1:0]),
    .funct3   (cur_f3),
    .wdata    (cur_wdata),
    .rword    (rword),
    .be       (be),
    .wword    (wword),
    .rdata    (rdata),
    .misalign (misalign)
  );

`ifdef DMEM_ERR_EN
  logic bad_f3, oob, unused_be;
  assign bad_f3    = (cur_f3 == 3'd3) || (cur_f3 > F3_HU) || (cur_write && cur_f3 > F3_W);
  assign oob       = (cur_addr >> 2) >= WIDTH'(DEPTH);
  assign err       = misalign | bad_f3 | oob;
  assign unused_be = ^be;
`else
  logic unused_bits;
  assign err         = 1'b0;
  assign unused_bits = ^{misalign, be, cur_addr};
`endif

  assign do_access = ((state == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                     ((state == WAIT) && (cnt == '0));
  assign ld_res    = (cur_write || err) ? '0 : rdata;

  // Memory is never cleared; reset only blocks an in-flight store.
  always_ff @(posedge clk) begin
    if (reset && do_access && cur_write && !err)
      mem[idx] <= wword;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      a_write   <= 1'b0;
      a_addr    <= '0;
      a_wdata   <= '0;
      a_f3      <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          a_write   <= req_write;
          a_addr    <= req_addr;
          a_wdata   <= req_wdata;
          a_f3      <= req_funct3;
          req_ready <= 1'b0;
          if (WAIT_CYCLES == 0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= ld_res;
            rsp_err   <= err;
          end else begin
            state <= WAIT;
            cnt   <= CW'(WAIT_CYCLES - 1);
          end
        end
        WAIT: if (cnt == '0) begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= ld_res;
          rsp_err   <= err;
        end else begin
          cnt <= cnt - 1'b1;
        end
        RESP: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Scoreboard bench for dmem_wait_responder: loads/stores of all widths, stall hold, reset abort, fault paths.
module tb_dmem_wait_responder;
  import dmem_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 1024;
  localparam int WC    = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid, req_ready, req_write;
  logic [WIDTH-1:0] req_addr, req_wdata;
  logic [2:0]       req_funct3;
  logic             rsp_valid, rsp_ready, rsp_err;
  logic [WIDTH-1:0] rsp_rdata;

  int n_chk  = 0;
  int n_fail = 0;
  logic [32:0] sb [$];

  always #5 clk = ~clk;

  dmem_wait_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Response monitor: the handshake happens at the next rising edge.
  always @(negedge clk) begin
    logic [32:0] e;
    if (reset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 32'd1);
      else begin
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e[31:0]);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e[32]});
      end
    end
  end

  task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [2:0] f3, input logic [31:0] er, input logic ee, input bit push);
    int n;
    @(negedge clk);
    req_write = wr; req_addr = addr; req_wdata = wd; req_funct3 = f3; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk("accept_ready", {31'b0, req_ready}, 32'd1);
    if (push) sb.push_back({ee, er});
    @(posedge clk);
    #1 req_valid = 1'b0;
    if (push) begin
      n = 0;
      while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
      chk("latency", 32'(n), 32'(WC + 1));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (rsp_valid && n < 50) begin @(negedge clk); n++; end
    chk("drain_idle", {31'b0, rsp_valid}, 32'd0);
  endtask

  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [2:0] f3, input logic [31:0] er, input logic ee);
    send(wr, addr, wd, f3, er, ee, 1'b1);
    drain();
  endtask

  initial begin
    reset = 1'b0; rsp_ready = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; req_funct3 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);

    xfer(1'b1, 32'h10, 32'hDEADBEEF, F3_W, 32'h0, 1'b0);
    xfer(1'b0, 32'h10, 32'h0, F3_W, 32'hDEADBEEF, 1'b0);
    xfer(1'b1, 32'h11, 32'h12345680, F3_B, 32'h0, 1'b0);
    xfer(1'b0, 32'h11, 32'h0, F3_B,  32'hFFFFFF80, 1'b0);
    xfer(1'b0, 32'h11, 32'h0, F3_BU, 32'h00000080, 1'b0);
    xfer(1'b0, 32'h10, 32'h0, F3_W,  32'hDEAD80EF, 1'b0);
    xfer(1'b1, 32'h12, 32'hAAAA8001, F3_H, 32'h0, 1'b0);
    xfer(1'b0, 32'h12, 32'h0, F3_H,  32'hFFFF8001, 1'b0);
    xfer(1'b0, 32'h12, 32'h0, F3_HU, 32'h00008001, 1'b0);
    xfer(1'b0, 32'h10, 32'h0, F3_B,  32'hFFFFFFEF, 1'b0);
    xfer(1'b0, 32'h13, 32'h0, F3_BU, 32'h00000080, 1'b0);
    xfer(1'b0, 32'h10, 32'h0, F3_H,  32'hFFFF80EF, 1'b0);
    xfer(1'b1, 32'h0,  32'h0BADF00D, F3_W, 32'h0, 1'b0);

    // Stall the response channel and confirm the response holds.
    rsp_ready = 1'b0;
    send(1'b0, 32'h10, 32'h0, F3_W, 32'h800180EF, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
      chk("hold_rdata", rsp_rdata, 32'h800180EF);
      chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_hs_req_ready", {31'b0, req_ready}, 32'd1);
    chk("post_hs_rsp_valid", {31'b0, rsp_valid}, 32'd0);

`ifdef DMEM_ERR_EN
    xfer(1'b0, 32'h12, 32'h0, F3_W, 32'h0, 1'b1);
    xfer(1'b0, 32'h11, 32'h0, F3_H, 32'h0, 1'b1);
    xfer(1'b0, 32'h10, 32'h0, 3'd3, 32'h0, 1'b1);
    xfer(1'b1, 32'h10, 32'h0, F3_BU, 32'h0, 1'b1);
    xfer(1'b1, 32'(DEPTH * 4), 32'h55555555, F3_W, 32'h0, 1'b1);
    xfer(1'b0, 32'h0,  32'h0, F3_W, 32'h0BADF00D, 1'b0);
    xfer(1'b0, 32'h10, 32'h0, F3_W, 32'h800180EF, 1'b0);
`else
    xfer(1'b0, 32'h12, 32'h0, F3_W, 32'h800180EF, 1'b0);
    xfer(1'b0, 32'h13, 32'h0, F3_H, 32'hFFFF8001, 1'b0);
`endif

    // A store aborted by reset while waiting must leave memory untouched.
    xfer(1'b1, 32'h20, 32'h11111111, F3_W, 32'h0, 1'b0);
    send(1'b1, 32'h20, 32'h22222222, F3_W, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("abort_req_ready", {31'b0, req_ready}, 32'd1);
    xfer(1'b0, 32'h20, 32'h0, F3_W, 32'h11111111, 1'b0);

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
